// File: rtl/prog_delay_line_pkg.sv
// Shared types and helpers for the programmable delay line.
package prog_delay_line_pkg;

    typedef enum logic [0:0] {Fill, Run} dl_state_e;

    localparam int unsigned DefaultMaxDepth = 90;

    function automatic int unsigned delay_sel_width(input int unsigned max_depth);
        return $clog2(max_depth + 1);
    endfunction

    localparam int unsigned DefaultDw = delay_sel_width(DefaultMaxDepth);

    // Zero is treated as the shortest legal delay; anything past the buffer saturates.
    function automatic int unsigned clamp_delay(input int unsigned x,
                                                input int unsigned max_depth);
        if (x == 0) return 1;
        if (x > max_depth) return max_depth;
        return x;
    endfunction

endpackage

// File: rtl/dline_ram.sv
// Sample storage: combinational read, synchronous write, read-before-write.
module dline_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 90,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_delay_line.sv
// Runtime-programmable sample delay line with zero-fill after reset or delay change.
// Optional fill_level output enabled by defining PROG_DELAY_LINE_FILL_LEVEL_EN.
module prog_delay_line
    import prog_delay_line_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_DEPTH = DefaultMaxDepth,
    parameter int unsigned DW        = delay_sel_width(MAX_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [DW-1:0]    delay_sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
`ifdef PROG_DELAY_LINE_FILL_LEVEL_EN
    output logic [DW-1:0]    fill_level,
`endif
    output logic             primed
);

    localparam int unsigned AW = $clog2(MAX_DEPTH);

    dl_state_e        state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [DW-1:0]    fill_q, fill_d;
    logic [DW-1:0]    d_act_q, d_act_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             primed_q, primed_d;

    logic             accept;
    logic             change;
    logic             run_out;
    logic [DW-1:0]    d_req;
    logic [DW:0]      wr_ext, d_ext, rd_full;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rdata;

    assign accept = ena && in_valid;
    assign d_req  = DW'(clamp_delay(32'(delay_sel), MAX_DEPTH));
    assign change = (d_req != d_act_q);

    // Circular subtraction; d_act == MAX_DEPTH lands back on wr_ptr.
    always_comb begin
        wr_ext  = (DW + 1)'(wr_ptr_q);
        d_ext   = (DW + 1)'(d_act_q);
        rd_full = (wr_ext >= d_ext) ? (wr_ext - d_ext)
                                    : (wr_ext + (DW + 1)'(MAX_DEPTH) - d_ext);
        rd_addr = AW'(rd_full);
    end

    dline_ram #(
        .WIDTH (WIDTH),
        .DEPTH (MAX_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (accept && rst_n),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_addr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= Fill;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            d_act_q     <= d_req;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            primed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            d_act_q     <= d_act_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            primed_q    <= primed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        d_act_d  = d_act_q;
        if (accept) begin
            wr_ptr_d = (wr_ptr_q == AW'(MAX_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            if (change) begin
                // The sample written on this accept already counts toward the new fill.
                d_act_d = d_req;
                fill_d  = DW'(1);
                state_d = (d_req == DW'(1)) ? Run : Fill;
            end else if (state_q == Fill) begin
                fill_d = fill_q + DW'(1);
                if (fill_d == d_act_q) state_d = Run;
            end
        end
    end

    always_comb begin
        run_out     = (state_q == Run) && !change;
        out_valid_d = accept;
        out_data_d  = out_data_q;
        primed_d    = primed_q;
        if (accept) begin
            primed_d   = run_out;
            out_data_d = run_out ? rdata : '0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign primed    = primed_q;
`ifdef PROG_DELAY_LINE_FILL_LEVEL_EN
    assign fill_level = fill_q;
`endif

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed self-checking bench for prog_delay_line (WIDTH=8, MAX_DEPTH=90).
module tb_prog_delay_line;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned MAX_DEPTH = 90;
    localparam int unsigned DW        = $clog2(MAX_DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [DW-1:0]    delay_sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             primed;
`ifdef PROG_DELAY_LINE_FILL_LEVEL_EN
    logic [DW-1:0]    fill_level;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    prog_delay_line #(
        .WIDTH     (WIDTH),
        .MAX_DEPTH (MAX_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .delay_sel  (delay_sel),
        .out_valid  (out_valid),
        .out_data   (out_data),
`ifdef PROG_DELAY_LINE_FILL_LEVEL_EN
        .fill_level (fill_level),
`endif
        .primed     (primed)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs, then sample 1 ns after the edge.
    task automatic step(input logic e, input logic v, input logic [WIDTH-1:0] d);
        ena      = e;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [DW-1:0] sel);
        delay_sel = sel;
        rst_n     = 1'b0;
        step(1'b0, 1'b0, '0);
        rst_n     = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] exp_d;
        rst_n     = 1'b0;
        ena       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        delay_sel = 7'd1;

        // Reset state
        do_reset(7'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_primed", 32'(primed), 32'd0);
`ifdef PROG_DELAY_LINE_FILL_LEVEL_EN
        check("rst_fill_level", 32'(fill_level), 32'd0);
`endif

        // 1. D=1
        step(1'b1, 1'b1, 8'h11);
        check("d1_valid0", 32'(out_valid), 32'd1);
        check("d1_data0", 32'(out_data), 32'h00);
        check("d1_primed0", 32'(primed), 32'd0);
        step(1'b1, 1'b1, 8'h22);
        check("d1_data1", 32'(out_data), 32'h11);
        check("d1_primed1", 32'(primed), 32'd1);
        step(1'b1, 1'b1, 8'h33);
        check("d1_data2", 32'(out_data), 32'h22);
        check("d1_primed2", 32'(primed), 32'd1);
        step(1'b1, 1'b0, 8'h00);
        check("d1_idle_valid", 32'(out_valid), 32'd0);
        check("d1_idle_hold", 32'(out_data), 32'h22);

        // 2. D=90 through pointer wrap
        do_reset(7'd90);
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b1, 8'(i));
            exp_d = (i < 90) ? 8'h00 : 8'(i - 90);
            check($sformatf("d90_data_%0d", i), 32'(out_data), 32'(exp_d));
            check($sformatf("d90_primed_%0d", i), 32'(primed), (i >= 90) ? 32'd1 : 32'd0);
`ifdef PROG_DELAY_LINE_FILL_LEVEL_EN
            check($sformatf("d90_fill_%0d", i), 32'(fill_level),
                  (i < 90) ? 32'(i + 1) : 32'd90);
`endif
        end

        // 3. D=30, change to 45 at sample 100; idle-cycle change is ignored
        do_reset(7'd30);
        for (int i = 0; i < 146; i++) begin
            if (i == 50) begin
                delay_sel = 7'd45;
                step(1'b1, 1'b0, 8'h00);
                check("d30_idle_change_valid", 32'(out_valid), 32'd0);
                delay_sel = 7'd30;
            end
            if (i == 100) delay_sel = 7'd45;
            step(1'b1, 1'b1, 8'(i));
            if (i < 100) exp_d = (i < 30) ? 8'h00 : 8'(i - 30);
            else exp_d = (i < 145) ? 8'h00 : 8'(i - 45);
            check($sformatf("chg_data_%0d", i), 32'(out_data), 32'(exp_d));
            if (i == 99 || i == 100 || i == 144 || i == 145)
                check($sformatf("chg_primed_%0d", i), 32'(primed),
                      (i == 99 || i == 145) ? 32'd1 : 32'd0);
        end

        // 4a. delay_sel=0 behaves as D=1; ena low drops the sample
        delay_sel = 7'd0;
        step(1'b1, 1'b1, 8'hA0);
        check("d0_data0", 32'(out_data), 32'h00);
        check("d0_primed0", 32'(primed), 32'd0);
        step(1'b0, 1'b1, 8'hEE);
        check("d0_ena_low_valid", 32'(out_valid), 32'd0);
        step(1'b1, 1'b0, 8'hEF);
        step(1'b1, 1'b1, 8'hA1);
        check("d0_data1", 32'(out_data), 32'hA0);
        check("d0_primed1", 32'(primed), 32'd1);
        step(1'b1, 1'b1, 8'hA2);
        check("d0_data2", 32'(out_data), 32'hA1);

        // 4b. over-range delay_sel behaves as D=90, gaps add no delay
        delay_sel = 7'd127;
        for (int j = 0; j < 95; j++) begin
            if (j % 7 == 3) begin
                step(1'b1, 1'b0, 8'hFF);
                check($sformatf("dmax_gap_%0d", j), 32'(out_valid), 32'd0);
            end
            if (j % 11 == 5) begin
                step(1'b0, 1'b1, 8'hFF);
                check($sformatf("dmax_ena_%0d", j), 32'(out_valid), 32'd0);
            end
            step(1'b1, 1'b1, 8'(j) ^ 8'h5A);
            exp_d = (j < 90) ? 8'h00 : (8'(j - 90) ^ 8'h5A);
            check($sformatf("dmax_data_%0d", j), 32'(out_data), 32'(exp_d));
        end

        // 5. Mid-stream reset at D=60, with a sample presented during reset
        do_reset(7'd60);
        for (int k = 0; k < 80; k++) step(1'b1, 1'b1, 8'(k + 7));
        check("pre_rst_primed", 32'(primed), 32'd1);
        rst_n = 1'b0;
        step(1'b1, 1'b1, 8'hFF);
        rst_n = 1'b1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_primed", 32'(primed), 32'd0);
        for (int m = 0; m < 65; m++) begin
            step(1'b1, 1'b1, 8'(m + 100));
            exp_d = (m < 60) ? 8'h00 : 8'(m + 40);
            check($sformatf("r60_data_%0d", m), 32'(out_data), 32'(exp_d));
            check($sformatf("r60_primed_%0d", m), 32'(primed), (m >= 60) ? 32'd1 : 32'd0);
`ifdef PROG_DELAY_LINE_FILL_LEVEL_EN
            check($sformatf("r60_fill_%0d", m), 32'(fill_level),
                  (m < 60) ? 32'(m + 1) : 32'd60);
`endif
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
